// File: rtl/rr_tx_pkg.sv
// rr_tx_pkg: shared FSM encoding and framing constants for the RR-interval UART transmitter.
package rr_tx_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int RECORD_BYTES = 6;
    localparam int RECORD_W = RECORD_BYTES * 8;
endpackage

// File: rtl/rr_fifo.sv
// rr_fifo: synchronous record FIFO; a push into a full FIFO is accepted only alongside a pop.
module rr_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    always_comb begin
        full = level == (AW+1)'(DEPTH);
        empty = level == '0;
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        dout = mem[rd_ptr];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/rr_uart_tx.sv
// rr_uart_tx: queues {R-peak index, RR period} records and ships each as a 6-byte 8N1 UART frame.
module rr_uart_tx
    import rr_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int CTR_WIDTH = 22,
    parameter int CLK_DIV = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic [DATA_WIDTH-1:0]         rr_period,
    input  logic                          rr_period_updated,
    input  logic [CTR_WIDTH-1:0]          r_peak_sample_num,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_TOP = BW'(CLK_DIV - 1);
    localparam int FW = CTR_WIDTH + DATA_WIDTH;
    state_t st;
    logic [BW-1:0] baud;
    logic [2:0] bit_idx, byte_idx;
    logic [RECORD_W-1:0] rec;
    logic [FW-1:0] head;
    logic [7:0] cur;
    logic full, empty, push, pop, tick;
    always_comb begin
        push = ce && rr_period_updated;
        pop = ce && st == LOAD;
        tick = baud == '0;
        cur = rec[RECORD_W-1 -: 8];
        busy = st != IDLE;
        uart_tx = st == START ? 1'b0 : st == DATA ? cur[bit_idx] : 1'b1;
    end
    rr_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({r_peak_sample_num, rr_period}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );
    // The record register shifts left one byte per STOP so the byte on the wire is always the top one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            baud <= '0;
            bit_idx <= '0;
            byte_idx <= '0;
            rec <= '0;
            overflow <= 1'b0;
        end else if (ce) begin
            if (push && full && !pop) overflow <= 1'b1;
            if (st != IDLE) baud <= (st == LOAD || tick) ? BAUD_TOP : baud - 1'b1;
            case (st)
                IDLE: if (!empty) st <= LOAD;
                LOAD: begin
                    rec <= {SYNC_BYTE, 24'(head[FW-1:DATA_WIDTH]), 16'(head[DATA_WIDTH-1:0])};
                    byte_idx <= '0;
                    st <= START;
                end
                START: if (tick) st <= DATA;
                DATA: if (tick) begin
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) st <= STOP;
                end
                STOP: if (tick) begin
                    if (byte_idx < 3'(RECORD_BYTES - 1)) begin
                        byte_idx <= byte_idx + 1'b1;
                        rec <= rec << 8;
                        st <= START;
                    end else st <= empty ? IDLE : LOAD;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_uart_tx.sv
// tb_rr_uart_tx: scoreboard bench; stimulus queues expected bytes, a line-level UART monitor checks them.
module tb_rr_uart_tx;
    localparam int DW = 11;
    localparam int CW = 22;
    localparam int DIV = 4;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b1;
    logic rr_period_updated = 1'b0;
    logic [DW-1:0] rr_period = '0;
    logic [CW-1:0] r_peak_sample_num = '0;
    logic uart_tx, busy, overflow;
    logic [$clog2(DEPTH):0] fifo_level;
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    logic [7:0] exp_q[$];
    int fall_q[$];
    int end_q[$];
    bit mon_active = 0;
    bit mon_have, mon_err;
    int mon_n;
    logic [7:0] mon_exp, mon_rx;
    logic mon_bit;

    rr_uart_tx #(.DATA_WIDTH(DW), .CTR_WIDTH(CW), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .ce                (ce),
        .rr_period         (rr_period),
        .rr_period_updated (rr_period_updated),
        .r_peak_sample_num (r_peak_sample_num),
        .uart_tx           (uart_tx),
        .busy              (busy),
        .overflow          (overflow),
        .fifo_level        (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic void push_record(input int rr, input int pk);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'((pk / 65536) % 256));
        exp_q.push_back(8'((pk / 256) % 256));
        exp_q.push_back(8'(pk % 256));
        exp_q.push_back(8'((rr / 256) % 256));
        exp_q.push_back(8'(rr % 256));
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int rr, input int pk, input bit accepted);
        rr_period = DW'(rr);
        r_peak_sample_num = CW'(pk);
        rr_period_updated = 1'b1;
        if (accepted) push_record(rr, pk);
        @(posedge clk);
        #1;
        rr_period_updated = 1'b0;
        strobe_cyc = cyc;
    endtask

    task automatic wait_falls(input int n, input int budget, input string nm);
        int k = 0;
        while (fall_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= budget) chk({nm, "_timeout"}, fall_q.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!(!busy && fifo_level == 0 && !mon_active) && k < budget);
        if (k >= budget) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: not idle after %0d cycles", nm, k);
        end
    endtask

    task automatic clear_log();
        fall_q.delete();
        end_q.delete();
    endtask

    // Counts only enabled cycles, so a frozen line stretches a bit without breaking the frame check.
    always @(negedge clk) begin
        if (rst) mon_active = 0;
        else if (ce) begin
            if (!mon_active && uart_tx == 1'b0) begin
                mon_active = 1;
                mon_n = 0;
                mon_err = 0;
                mon_rx = '0;
                fall_q.push_back(cyc);
                mon_have = exp_q.size() > 0;
                if (mon_have) mon_exp = exp_q.pop_front();
                else begin
                    mon_exp = 8'h00;
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_byte: start bit at cycle %0d with empty scoreboard", cyc);
                end
            end
            if (mon_active) begin
                mon_bit = mon_n < DIV ? 1'b0 : mon_n >= 9 * DIV ? 1'b1 : mon_exp[3'(mon_n / DIV - 1)];
                if (mon_n >= DIV && mon_n < 9 * DIV && mon_n % DIV == DIV / 2)
                    mon_rx[3'(mon_n / DIV - 1)] = uart_tx;
                if (uart_tx !== mon_bit) mon_err = 1;
                mon_n++;
                if (mon_n == 10 * DIV) begin
                    end_q.push_back(cyc);
                    mon_active = 0;
                    if (mon_have) begin
                        compared++;
                        if (mon_err) begin
                            mismatched++;
                            $display("FAIL byte: got 0x%02h, expected 0x%02h (frame ending cycle %0d)", mon_rx, mon_exp, cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int bad;
        step(3);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        rst = 1'b0;
        step(3);

        clear_log();
        strobe(360, 1000, 1);
        wait_idle(400, "single");
        chk("single_bytes", fall_q.size(), 6);
        if (fall_q.size() == 6) begin
            chk("single_start_latency", fall_q[0] - strobe_cyc, 2);
            chk("single_span", end_q[5] - fall_q[0] + 1, 240);
        end
        step(2);

        clear_log();
        strobe(2047, 'h3FFFFF, 1);
        wait_idle(400, "maxval");
        chk("maxval_bytes", fall_q.size(), 6);
        step(2);

        clear_log();
        strobe(1234, 'h2ABCDE, 1);
        strobe(5, 7, 1);
        wait_idle(700, "b2b");
        chk("b2b_bytes", fall_q.size(), 12);
        if (fall_q.size() == 12) begin
            bad = 0;
            for (int i = 1; i < 12; i++)
                if (i != 6 && fall_q[i] - fall_q[i-1] != 40) bad++;
            chk("b2b_byte_gaps", bad, 0);
            chk("b2b_record_gap", fall_q[6] - fall_q[5], 41);
        end
        step(2);

        for (int b = 0; b < 6; b++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int r = 0; r < n; r++) begin
                strobe($urandom_range(0, 2047), int'($urandom & 32'h3FFFFF), 1);
                step($urandom_range(0, 3));
            end
            wait_idle(8 * 250 + 100, "burst");
            chk("burst_drained", exp_q.size(), 0);
            step(2);
        end
        chk("burst_no_overflow", overflow, 0);

        clear_log();
        strobe(500, 12345, 1);
        wait_falls(2, 200, "ce");
        step(5);
        for (int i = 0; i < 20; i++) begin
            ce = 1'b0;
            rr_period = DW'(i);
            rr_period_updated = (i % 4 == 0);
            step(1);
        end
        ce = 1'b1;
        rr_period_updated = 1'b0;
        wait_idle(500, "ce");
        chk("ce_bytes", fall_q.size(), 6);
        if (fall_q.size() == 6) chk("ce_span", end_q[5] - fall_q[0] + 1, 260);
        chk("ce_level", fifo_level, 0);
        chk("ce_overflow", overflow, 0);
        step(2);

        clear_log();
        for (int i = 0; i < 10; i++) strobe(100 + i, 5000 + i, i < 9);
        chk("ovf_level", fifo_level, 8);
        chk("ovf_flag_early", overflow, 1);
        wait_idle(9 * 250 + 200, "ovf");
        chk("ovf_flag", overflow, 1);
        chk("ovf_bytes", fall_q.size(), 54);
        chk("ovf_drained", exp_q.size(), 0);
        step(2);

        clear_log();
        strobe(77, 88, 1);
        strobe(99, 111, 1);
        wait_falls(4, 400, "rstmid");
        step(12);
        chk("rstmid_busy_before", busy, 1);
        chk("rstmid_level_before", fifo_level, 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rstmid_uart_tx", uart_tx, 1);
        chk("rstmid_level", fifo_level, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_overflow", overflow, 0);
        step(3);
        rst = 1'b0;
        step(300);
        chk("rstmid_no_resume", fall_q.size(), 4);
        chk("rstmid_idle_line", uart_tx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rr_uart_tx.md
RR_UART_TX -- requirements
Module: rr_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11: width of rr_period.
REQ-002 SHALL have parameter CTR_WIDTH, default 22: width of r_peak_sample_num.
REQ-003 SHALL have parameter CLK_DIV, default 868: clock cycles per UART bit (100 MHz / 115200).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8: result records buffered (power of 2).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port ce  input  1  clock enable; 0 freezes all state.
REQ-008 SHALL have port rr_period  input  DATA_WIDTH  RR interval in samples, unsigned.
REQ-009 SHALL have port rr_period_updated  input  1  one-cycle strobe qualifying rr_period and r_peak_sample_num.
REQ-010 SHALL have port r_peak_sample_num  input  CTR_WIDTH  sample index of the detected R peak.
REQ-011 SHALL have port uart_tx  output  1  serial line, 8N1, idle high.
REQ-012 SHALL have port busy  output  1  high while a record is being shifted out.
REQ-013 SHALL have port overflow  output  1  sticky flag: a record was dropped.
REQ-014 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  records currently queued.

Function
REQ-015 SHALL push {r_peak_sample_num, rr_period} into the FIFO on any edge with ce=1 and rr_period_updated=1.
REQ-016 SHALL drop the push and set overflow when the FIFO is full, unless a pop occurs on the same edge, in which case the push SHALL be accepted.
REQ-017 SHALL transmit each record as 6 bytes: 0xA5, r_peak_sample_num zero-extended to 24 bits MSB-byte first (3 bytes), rr_period zero-extended to 16 bits MSB-byte first (2 bytes).
REQ-018 SHALL send each byte as: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly CLK_DIV enabled cycles.
REQ-019 SHALL implement FSM states IDLE, LOAD, START, DATA, STOP.
REQ-020 IDLE: uart_tx=1, busy=0; go to LOAD when FIFO non-empty.
REQ-021 LOAD: one cycle; pop FIFO head into a 48-bit shift record; byte index=0; busy=1; go to START.
REQ-022 START -> DATA -> STOP per bit timing; bit counter 0..7 in DATA.
REQ-023 STOP end: if byte index<5, increment and go to START with no idle gap; else go to LOAD if FIFO non-empty, otherwise IDLE.
REQ-024 From an idle block, uart_tx SHALL fall on the 2nd enabled rising edge after the sampled strobe.
REQ-025 Baud counter SHALL count CLK_DIV-1 down to 0 and reload; no cumulative drift across a record (60*CLK_DIV cycles per record).
REQ-026 With ce=0, counters, FSM, FIFO and uart_tx SHALL hold; strobes SHALL be ignored.
REQ-027 overflow SHALL clear only on reset.

Reset
REQ-028 On rst=1, asynchronously: uart_tx=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, all counters 0, FIFO pointers 0.
REQ-029 Reset mid-frame SHALL abort the frame immediately; no partial byte resumes after release.

Structure
REQ-030 Package rr_tx_pkg SHALL hold the FSM state enum, SYNC_BYTE=8'hA5, RECORD_BYTES=6 and the record width constant.
REQ-031 The FIFO SHALL be a sub-module rr_fifo (synchronous, first-word registered, full/empty/level outputs).

Verification (CLK_DIV=4 in bench)
REQ-032 One strobe, rr_period=360, r_peak_sample_num=1000 -> bytes A5 00 03 E8 01 68, start bit on 2nd edge, record spans 240 cycles.
REQ-033 10 strobes on consecutive cycles from idle -> exactly 9 records sent in push order, overflow=1, 10th record absent.
REQ-034 Two queued records -> second record start bit exactly 1 cycle after first record's last stop bit ends; no gap between bytes within a record.
REQ-035 rst asserted mid-DATA of byte 3 -> uart_tx=1 same cycle, fifo_level=0, no further bytes after release.
REQ-036 ce=0 held 20 cycles mid-bit -> bit duration extended by exactly 20 cycles, strobes during that window not queued.
REQ-037 rr_period=2047, r_peak_sample_num=22'h3FFFFF -> bytes A5 3F FF FF 07 FF.
